// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order responses into a 2-entry decode buffer, redirect with stale-response discard.
// Response-to-dec_valid latency is one cycle; requests are throttled so outstanding + buffered never exceeds BUF_DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pcplus4,
  output logic        dec_illegal
);

  localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding, outstanding_nxt;
  logic [1:0]  discard, discard_nxt;
  logic [31:0] pcq0, pcq1;
  logic [31:0] buf_instr0, buf_instr1, buf_pc0, buf_pc1;
  logic [1:0]  occ;
  logic        grant, rsp, accept, pop, opcode_ok;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_req  = (state != BOOT) && !redirect &&
                     (({1'b0, outstanding} + {1'b0, occ}) < CREDITS);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  // Responses with nothing outstanding are stray and must not disturb any state.
  assign rsp       = imem_rvalid & (outstanding != 2'd0);
  assign accept    = rsp & ~redirect & (discard == 2'd0);
  assign pop       = dec_valid & dec_ready;

  assign outstanding_nxt = outstanding + {1'b0, grant} - {1'b0, rsp};

  always_comb begin
    discard_nxt = discard;
    if (redirect)
      discard_nxt = outstanding - {1'b0, rsp};
    else if (rsp && discard != 2'd0)
      discard_nxt = discard - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (redirect && outstanding != 2'd0) state_nxt = DRAIN;
      DRAIN:   if (discard_nxt == 2'd0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      pcq0        <= 32'd0;
      pcq1        <= 32'd0;
      buf_instr0  <= 32'd0;
      buf_instr1  <= 32'd0;
      buf_pc0     <= 32'd0;
      buf_pc1     <= 32'd0;
      occ         <= 2'd0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;

      if (redirect)   fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (grant) fetch_pc <= fetch_pc + 32'd4;

      // Per-request PC queue; the head always belongs to the oldest outstanding request.
      case ({grant, rsp})
        2'b10: if (outstanding == 2'd0) pcq0 <= fetch_pc;
               else                     pcq1 <= fetch_pc;
        2'b01: pcq0 <= pcq1;
        2'b11: if (outstanding == 2'd1) pcq0 <= fetch_pc;
               else begin
                 pcq0 <= pcq1;
                 pcq1 <= fetch_pc;
               end
        default: ;
      endcase

      if (redirect) begin
        occ <= 2'd0;
      end else begin
        case ({accept, pop})
          2'b10: begin
            if (occ == 2'd0) begin
              buf_instr0 <= imem_rdata;
              buf_pc0    <= pcq0;
            end else begin
              buf_instr1 <= imem_rdata;
              buf_pc1    <= pcq0;
            end
            occ <= occ + 2'd1;
          end
          2'b01: begin
            buf_instr0 <= buf_instr1;
            buf_pc0    <= buf_pc1;
            occ        <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              buf_instr0 <= imem_rdata;
              buf_pc0    <= pcq0;
            end else begin
              buf_instr0 <= buf_instr1;
              buf_pc0    <= buf_pc1;
              buf_instr1 <= imem_rdata;
              buf_pc1    <= pcq0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    opcode_ok = 1'b0;
    case (buf_instr0[6:0])
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b1100011, 7'b0010011, 7'b1101111: opcode_ok = 1'b1;
      default:                            opcode_ok = 1'b0;
    endcase
  end

  assign dec_valid   = (occ != 2'd0);
  assign dec_instr   = buf_instr0;
  assign dec_pc      = buf_pc0;
  assign dec_pcplus4 = buf_pc0 + 32'd4;
  assign dec_illegal = dec_valid & ((buf_instr0[1:0] != 2'b11) | ~opcode_ok);

endmodule
